mcc_mem_port: RTL and testbench

Memory access port for the multi-cycle CPU. It sits between the controller's memory-control outputs and a shared instruction/data memory that uses a request/grant/valid handshake. The block latches each controller access request, runs the handshake with wait states, and captures returned data into the instruction register or the memory data register. It raises `busy_o` so the controller can stall, and flags misaligned or timed-out accesses.

---
 rtl/mcc_mem_pkg.sv | 24 ++
 rtl/mcc_mem_timer.sv | 36 +++
 rtl/mcc_mem_port.sv | 162 ++++++++++++++++
 tb/tb_mcc_mem_port.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcc_mem_pkg.sv
// mcc_mem_pkg
// Shared definitions for the multi-cycle CPU memory port: FSM state encoding,
// IorD address-select codes, instruction field positions and the default
// access timeout.
package mcc_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // IorD select: 0 picks the PC, every other code picks ALUOut.
  localparam logic [1:0] IORD_PC  = 2'd0;
  localparam logic [1:0] IORD_ALU = 2'd1;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mcc_mem_timer.sv
// mcc_mem_timer
// Saturating access-duration counter used to abort stuck memory handshakes.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   clr_i        hold the count at zero
//   en_i         count one cycle
//   expired_o    current cycle is the last one allowed (count == LIMIT-1),
//                so the abort lands on the edge where the count reaches LIMIT
module mcc_mem_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int              CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired_o = (cnt_q >= LAST);

endmodule

// File: rtl/mcc_mem_port.sv
// mcc_mem_port
// Memory access port for the multi-cycle CPU. Latches one controller access,
// runs the req/gnt/rvalid handshake and captures read data into the IR or MDR.
// Ports:
//   pc_i, alu_out_i, wdata_i, iord_i    address sources, store data, select
//   mem_read_i, mem_write_i, ir_write_i controller access request
//   m_req_o, m_we_o, m_addr_o, m_wdata_o memory request side (registered)
//   m_gnt_i, m_rvalid_i, m_rdata_i       memory response side
//   instr_o, opcode_o, funct_o, mdr_o    captured read data
//   busy_o                               access in flight (controller stalls)
//   err_o                                sticky: misaligned, read+write, timeout
//
// state | meaning
// IDLE  | sample controller request, reject bad ones
// REQ   | m_req_o high, address/data held until m_gnt_i
// WAIT  | read granted, waiting for m_rvalid_i
module mcc_mem_port
  import mcc_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] alu_out_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [1:0]        iord_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              ir_write_i,
  output logic              m_req_o,
  output logic              m_we_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [DATA_W-1:0] m_wdata_o,
  input  logic              m_gnt_i,
  input  logic              m_rvalid_i,
  input  logic [DATA_W-1:0] m_rdata_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [5:0]        opcode_o,
  output logic [5:0]        funct_o,
  output logic [DATA_W-1:0] mdr_o,
  output logic              busy_o,
  output logic              err_o
);

  state_e            state_q;
  logic              m_req_q;
  logic              m_we_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q;
  logic              ir_tgt_q;
  logic [DATA_W-1:0] instr_q;
  logic [DATA_W-1:0] mdr_q;
  logic              busy_q;
  logic              err_q;

  logic [ADDR_W-1:0] req_addr;
  logic              req_any;
  logic              req_bad;
  logic              timer_clr;
  logic              timer_en;
  logic              timer_expired;

  assign req_addr = (iord_i == IORD_PC) ? pc_i : alu_out_i;
  assign req_any  = mem_read_i | mem_write_i;
  assign req_bad  = (mem_read_i & mem_write_i) | (req_addr[1:0] != 2'b00);

  // Held clear while idle, so the count is zero on every entry to REQ.
  assign timer_clr = (state_q == ST_IDLE);
  assign timer_en  = (state_q != ST_IDLE);

  mcc_mem_timer #(
    .LIMIT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (timer_clr),
    .en_i      (timer_en),
    .expired_o (timer_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      ir_tgt_q  <= 1'b0;
      instr_q   <= '0;
      mdr_q     <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_any) begin
            if (req_bad) begin
              err_q <= 1'b1;
            end else begin
              state_q   <= ST_REQ;
              m_req_q   <= 1'b1;
              busy_q    <= 1'b1;
              m_addr_q  <= req_addr;
              m_we_q    <= mem_write_i;
              m_wdata_q <= wdata_i;
              ir_tgt_q  <= ir_write_i && (iord_i == IORD_PC);
            end
          end
        end
        ST_REQ: begin
          // A grant on the final allowed cycle still completes the handshake.
          if (m_gnt_i) begin
            m_req_q <= 1'b0;
            if (m_we_q) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_WAIT;
            end
          end else if (timer_expired) begin
            state_q <= ST_IDLE;
            m_req_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end
        end
        ST_WAIT: begin
          // Data arriving on the expiry cycle wins over the timeout.
          if (m_rvalid_i) begin
            if (ir_tgt_q) begin
              instr_q <= m_rdata_i;
            end else begin
              mdr_q <= m_rdata_i;
            end
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (timer_expired) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_req_o   = m_req_q;
  assign m_we_o    = m_we_q;
  assign m_addr_o  = m_addr_q;
  assign m_wdata_o = m_wdata_q;
  assign instr_o   = instr_q;
  assign opcode_o  = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign funct_o   = instr_q[FUNCT_MSB:FUNCT_LSB];
  assign mdr_o     = mdr_q;
  assign busy_o    = busy_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_mcc_mem_port.sv
// tb_mcc_mem_port
// Scoreboard bench for mcc_mem_port: the stimulus computes each access's
// outcome from the port's rules (address select, alignment, total handshake
// cycles vs. timeout) and queues it; a memory responder plays the handshake
// with the chosen delays; a monitor checks every grant and every completion.
module tb_mcc_mem_port;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_i, alu_out_i, wdata_i;
  logic [1:0]  iord_i;
  logic        mem_read_i, mem_write_i, ir_write_i;
  logic        m_req_o, m_we_o;
  logic [31:0] m_addr_o, m_wdata_o;
  logic        m_gnt_i, m_rvalid_i;
  logic [31:0] m_rdata_i;
  logic [31:0] instr_o, mdr_o;
  logic [5:0]  opcode_o, funct_o;
  logic        busy_o, err_o;

  always #5 clk = ~clk;

  mcc_mem_port #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .pc_i(pc_i), .alu_out_i(alu_out_i), .wdata_i(wdata_i), .iord_i(iord_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .ir_write_i(ir_write_i),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
    .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i),
    .instr_o(instr_o), .opcode_o(opcode_o), .funct_o(funct_o), .mdr_o(mdr_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  typedef struct { logic we; int gd; int rvd; logic [31:0] data; } rsp_t;
  typedef struct { logic [31:0] addr; logic we; logic [31:0] wd; } req_t;
  typedef struct { int dur; logic [31:0] instr; logic [31:0] mdr; logic err; } cmp_t;

  rsp_t rsp_q[$];
  req_t req_q[$];
  cmp_t cmp_q[$];
  logic rsp_active = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_instr = '0, m_mdr = '0;
  logic        m_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder.
  initial begin
    rsp_t r;
    m_gnt_i = 1'b0; m_rvalid_i = 1'b0; m_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (m_req_o && rsp_q.size() > 0) begin
        rsp_active = 1'b1;
        r = rsp_q.pop_front();
        for (int i = 0; i < r.gd && m_req_o; i++) @(negedge clk);
        if (m_req_o) begin
          m_gnt_i = 1'b1;
          @(negedge clk);
          m_gnt_i = 1'b0;
          if (!r.we) begin
            for (int i = 0; i < r.rvd; i++) @(negedge clk);
            m_rvalid_i = 1'b1; m_rdata_i = r.data;
            @(negedge clk);
            m_rvalid_i = 1'b0; m_rdata_i = $urandom;
          end
        end
        rsp_active = 1'b0;
      end
    end
  end

  // Monitor: grants, address/data stability, and completions.
  initial begin
    logic        prev_busy = 1'b0, prev_req = 1'b0, prev_we = 1'b0;
    logic [31:0] prev_addr = '0, prev_wd = '0;
    int          run = 0;
    req_t        q;
    cmp_t        c;
    forever begin
      @(negedge clk); #2;
      if (reset) begin
        prev_busy = 1'b0; prev_req = 1'b0; run = 0;
      end else begin
        if (m_req_o && prev_req)
          chk("req_hold", {m_we_o, m_addr_o, m_wdata_o}, {prev_we, prev_addr, prev_wd});
        if (m_req_o && m_gnt_i) begin
          if (req_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL grant_unexpected: addr %0h with no queued access", m_addr_o);
          end else begin
            q = req_q.pop_front();
            chk("gnt_addr", m_addr_o, q.addr);
            chk("gnt_we", m_we_o, q.we);
            chk("gnt_wdata", m_wdata_o, q.wd);
          end
        end
        if (busy_o) begin
          run++;
        end else if (prev_busy) begin
          if (cmp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL done_unexpected: busy dropped with no queued access");
          end else begin
            c = cmp_q.pop_front();
            chk("busy_cycles", run, c.dur);
            chk("instr", instr_o, c.instr);
            chk("opcode", opcode_o, c.instr[31:26]);
            chk("funct", funct_o, c.instr[5:0]);
            chk("mdr", mdr_o, c.mdr);
            chk("err", err_o, c.err);
          end
          run = 0;
        end
        prev_busy = busy_o; prev_req = m_req_o;
        prev_we = m_we_o; prev_addr = m_addr_o; prev_wd = m_wdata_o;
      end
    end
  end

  task automatic drive_req(input logic rd, input logic wr, input logic [1:0] iord,
                           input logic irw, input logic [31:0] pc, input logic [31:0] alu,
                           input logic [31:0] wd);
    @(negedge clk);
    mem_read_i = rd; mem_write_i = wr; iord_i = iord; ir_write_i = irw;
    pc_i = pc; alu_out_i = alu; wdata_i = wd;
    @(posedge clk); #1;
    mem_read_i = 1'b0; mem_write_i = 1'b0;
    iord_i = 2'($urandom_range(0, 3)); ir_write_i = 1'($urandom_range(0, 1));
    pc_i = $urandom; alu_out_i = $urandom; wdata_i = $urandom;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk); #1; k++;
    end while ((busy_o || rsp_active) && k < 300);
    if (k >= 300) begin
      n_checks++; n_fail++;
      $display("FAIL %s: access did not finish within 300 cycles", name);
    end
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [1:0] iord,
                       input logic irw, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] wd, input int gd, input int rvd,
                       input logic [31:0] data);
    logic [31:0] addr;
    int          total;
    logic        tmo;
    addr = (iord == 2'd0) ? pc : alu;
    if ((rd && wr) || addr[1:0] != 2'b00) begin
      m_err = 1'b1;
      drive_req(rd, wr, iord, irw, pc, alu, wd);
      @(negedge clk); #1;
      chk("bad_err", err_o, 1'b1);
      chk("bad_no_req", m_req_o, 1'b0);
      chk("bad_no_busy", busy_o, 1'b0);
    end else begin
      total = (gd + 1) + (wr ? 0 : rvd + 1);
      tmo   = (total > TO);
      rsp_q.push_back('{we: wr, gd: gd, rvd: rvd, data: data});
      if (gd < TO) req_q.push_back('{addr: addr, we: wr, wd: wd});
      if (tmo) m_err = 1'b1;
      else if (!wr) begin
        if (irw && iord == 2'd0) m_instr = data;
        else m_mdr = data;
      end
      cmp_q.push_back('{dur: (tmo ? TO : total), instr: m_instr, mdr: m_mdr, err: m_err});
      drive_req(rd, wr, iord, irw, pc, alu, wd);
      wait_idle("access");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    int          r, k;
    reset = 1'b1;
    mem_read_i = 1'b0; mem_write_i = 1'b0; ir_write_i = 1'b0; iord_i = 2'd0;
    pc_i = '0; alu_out_i = '0; wdata_i = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", m_req_o, 1'b0);
    chk("rst_we", m_we_o, 1'b0);
    chk("rst_addr", m_addr_o, 32'h0);
    chk("rst_wdata", m_wdata_o, 32'h0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_mdr", mdr_o, 32'h0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    @(negedge clk); reset = 1'b0;

    // Zero-wait fetch.
    issue(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0040, 32'h0, 32'h0, 0, 0, 32'h2008_0005);
    chk("fetch_opcode", opcode_o, 6'h08);
    chk("fetch_funct", funct_o, 6'h05);
    // lw with gnt +3 and rvalid +2: busy for 7 cycles.
    issue(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0044, 32'h100, 32'h0, 3, 2, 32'hDEAD_BEEF);
    // sw with a delayed grant.
    issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0048, 32'h200, 32'h1234_5678, 2, 0, 32'h0);
    // Grant or data on the very last allowed cycle still completes.
    issue(1'b0, 1'b1, 2'd3, 1'b0, 32'h0, 32'h204, 32'hA5A5_0001, TO - 1, 0, 32'h0);
    issue(1'b1, 1'b0, 2'd1, 1'b0, 32'h0, 32'h208, 32'h0, 2, TO - 4, 32'h5A5A_1234);
    chk("boundary_no_err", err_o, 1'b0);

    // Reset while waiting for read data.
    rsp_q.push_back('{we: 1'b0, gd: 0, rvd: 20, data: 32'h1111_2222});
    req_q.push_back('{addr: 32'h44, we: 1'b0, wd: 32'h0});
    drive_req(1'b1, 1'b0, 2'd0, 1'b1, 32'h44, 32'h0, 32'h0);
    k = 0;
    do begin @(negedge clk); #1; k++; end while (!(busy_o && !m_req_o) && k < 50);
    chk("reached_wait", busy_o && !m_req_o, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rstw_req", m_req_o, 1'b0);
    chk("rstw_busy", busy_o, 1'b0);
    chk("rstw_instr", instr_o, 32'h0);
    chk("rstw_mdr", mdr_o, 32'h0);
    @(negedge clk); #4 reset = 1'b0;
    m_instr = '0; m_mdr = '0; m_err = 1'b0;
    wait_idle("rst_rsp");
    chk("rstw_late_rvalid_ignored", instr_o, 32'h0);
    issue(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0080, 32'h0, 32'h0, 1, 1, 32'h0C00_0123);

    // Misaligned, then read+write together: err from T+1 and held.
    issue(1'b1, 1'b0, 2'd1, 1'b0, 32'h0, 32'h102, 32'h0, 0, 0, 32'h0);
    issue(1'b1, 1'b1, 2'd0, 1'b0, 32'h40, 32'h0, 32'h0, 0, 0, 32'h0);
    repeat (3) @(negedge clk);
    #1 chk("err_sticky", err_o, 1'b1);

    // Grant never comes, then a read whose data arrives after the abort.
    issue(1'b1, 1'b0, 2'd0, 1'b1, 32'h84, 32'h0, 32'h0, 100, 0, 32'hFFFF_FFFF);
    issue(1'b1, 1'b0, 2'd1, 1'b0, 32'h0, 32'h300, 32'h0, 1, 12, 32'hCAFE_F00D);
    chk("late_mdr", mdr_o, m_mdr);
    chk("late_instr", instr_o, m_instr);

    // Clear the sticky error and run randomized traffic.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    m_instr = '0; m_mdr = '0; m_err = 1'b0;
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 99);
      a = $urandom; a[1:0] = 2'b00;
      b = $urandom; b[1:0] = 2'b00;
      if (r < 30)
        issue(1'b1, 1'b0, 2'd0, 1'b1, a, b, $urandom, $urandom_range(0, 3),
              $urandom_range(0, 4), $urandom);
      else if (r < 60)
        issue(1'b1, 1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, b,
              $urandom, $urandom_range(0, 3), $urandom_range(0, 4), $urandom);
      else if (r < 85)
        issue(1'b0, 1'b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, b,
              $urandom, $urandom_range(0, 3), 0, 32'h0);
      else if (r < 90) begin
        a[1:0] = 2'($urandom_range(1, 3)); b[1:0] = 2'($urandom_range(1, 3));
        issue(1'b1, 1'b0, 2'($urandom_range(0, 3)), 1'b0, a, b, $urandom, 0, 0, 32'h0);
      end else if (r < 93)
        issue(1'b1, 1'b1, 2'($urandom_range(0, 3)), 1'b0, a, b, $urandom, 0, 0, 32'h0);
      else
        issue(1'b1, 1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, b,
              $urandom, $urandom_range(0, 10), $urandom_range(0, 10), $urandom);
    end

    repeat (5) @(negedge clk);
    chk("req_q_drained", req_q.size(), 0);
    chk("cmp_q_drained", cmp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
